wb_block_mover: RTL and testbench

Wishbone classic initiator that moves a block of 32-bit words between a local valid/ready stream and any Wishbone responder on the user-area bus, including the TMS1x00 wrapper's program-RAM port and the 2 kB OpenRAM behind it. It drives the side of the bus that the management SoC normally drives. The block serves two roles: on-chip program loading from a streaming source, and bench-side read-back of RAM contents. Every transfer is a single-word classic cycle with full `sel`.

---
 rtl/wb_block_mover_pkg.sv | 16 +
 rtl/wb_ack_timer.sv | 23 ++
 rtl/wb_block_mover.sv | 117 +++++++++++
 tb/tb_wb_block_mover.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_block_mover_pkg.sv
// wb_block_mover_pkg: shared state encoding and bus constants for the Wishbone block mover
package wb_block_mover_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_BUS,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [3:0]  WB_SEL_ALL = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam int          MAX_LEN    = 512;

endpackage

// File: rtl/wb_ack_timer.sv
// wb_ack_timer: counts unacknowledged bus cycles and flags the last one allowed
module wb_ack_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [15:0] r_cnt;

  // wait counter, held at zero whenever no bus cycle is pending
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) r_cnt <= '0;
    else if (i_enable) r_cnt <= r_cnt + 16'd1;
  end

  // the current cycle is the TIMEOUT-th one spent waiting for ack
  assign o_expired = r_cnt == 16'(TIMEOUT - 1);

endmodule

// File: rtl/wb_block_mover.sv
// wb_block_mover: Wishbone classic initiator moving word blocks between the bus and valid/ready streams
module wb_block_mover
  import wb_block_mover_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int LEN_W   = 10
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [31:0]      cmd_base_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [31:0]      wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [31:0]      rd_data_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  state_t           r_state, w_next;
  logic             r_we, r_err;
  logic [31:0]      r_adr, r_dat, r_rd;
  logic [LEN_W-1:0] r_rem, w_len;
  logic             w_accept, w_bus, w_ack, w_expired;

  assign w_accept = r_state == S_IDLE && cmd_valid_i;
  assign w_bus    = r_state == S_BUS;
  assign w_ack    = w_bus && wbm_ack_i;
  // lengths above the supported maximum are clamped rather than overrunning the block
  assign w_len    = (int'(cmd_len_i) > MAX_LEN) ? LEN_W'(MAX_LEN) : cmd_len_i;

  wb_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk     (wb_clk_i),
    .i_rst_n   (wb_rst_n_i),
    .i_clear   (!w_bus),
    .i_enable  (w_bus && !wbm_ack_i),
    .o_expired (w_expired)
  );

  // state register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  // next state; an ack in the expiry cycle still completes the word
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid_i) w_next = (w_len == '0) ? S_DONE : cmd_we_i ? S_FETCH : S_BUS;
      S_FETCH: if (wr_valid_i) w_next = S_BUS;
      S_BUS: begin
        if (wbm_ack_i) w_next = !r_we ? S_HOLD : (r_rem == LEN_W'(1)) ? S_DONE : S_FETCH;
        else if (w_expired) w_next = S_DONE;
      end
      S_HOLD:  if (rd_ready_i) w_next = (r_rem == '0) ? S_DONE : S_BUS;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // command latch, word counters, data capture and sticky timeout flag
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_we  <= 1'b0;
      r_err <= 1'b0;
      r_adr <= '0;
      r_dat <= '0;
      r_rd  <= '0;
      r_rem <= '0;
    end else begin
      if (w_accept) begin
        r_we  <= cmd_we_i;
        r_adr <= {cmd_base_i[31:2], 2'b00};
        r_rem <= w_len;
        r_err <= 1'b0;
      end
      if (r_state == S_FETCH && wr_valid_i) r_dat <= wr_data_i;
      if (w_ack) begin
        r_rem <= r_rem - LEN_W'(1);
        r_adr <= r_adr + WORD_BYTES;
        if (!r_we) r_rd <= wbm_dat_i;
      end else if (w_bus && w_expired) begin
        r_err <= 1'b1;
      end
    end
  end

  assign cmd_ready_o = r_state == S_IDLE;
  assign wr_ready_o  = r_state == S_FETCH;
  assign rd_valid_o  = r_state == S_HOLD;
  assign rd_data_o   = r_rd;
  assign wbm_cyc_o   = w_bus;
  assign wbm_stb_o   = w_bus;
  assign wbm_we_o    = w_bus && r_we;
  assign wbm_sel_o   = w_bus ? WB_SEL_ALL : 4'h0;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;
  assign busy_o      = r_state != S_IDLE;
  assign done_o      = r_state == S_DONE;
  assign err_o       = r_err;

endmodule

// File: tb/tb_wb_block_mover.sv
// tb_wb_block_mover: directed and randomized checks of the block mover against a transaction-level model
module tb_wb_block_mover;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [31:0] cmd_base = '0;
  logic [9:0]  cmd_len = '0;
  logic        wr_valid = 1'b0, rd_ready = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] dat_i = '0;
  logic        r_ack = 1'b0, stray = 1'b0, ack;
  logic        cmd_ready, wr_ready, rd_valid, cyc, stb, we, busy, done, err;
  logic [3:0]  sel;
  logic [31:0] rd_data, adr, dat_o;

  assign ack = r_ack | stray;

  wb_block_mover #(.TIMEOUT(8), .LEN_W(10)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_base_i  (cmd_base),
    .cmd_len_i   (cmd_len),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_data_i   (wr_data),
    .rd_valid_o  (rd_valid),
    .rd_ready_i  (rd_ready),
    .rd_data_o   (rd_data),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_sel_o   (sel),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (dat_o),
    .wbm_dat_i   (dat_i),
    .wbm_ack_i   (ack),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // responder: 2 kB RAM aliased on address bits [10:2], acks after lat extra wait cycles
  logic [31:0] mem [512];
  int          lat = 0, wcnt = 0;
  bit          resp_en = 1'b1;
  always @(posedge clk) begin
    if (!(cyc && stb) || r_ack) begin
      r_ack <= 1'b0;
      wcnt  <= 0;
    end else if (resp_en && wcnt >= lat) begin
      r_ack <= 1'b1;
      dat_i <= mem[adr[10:2]];
      if (we) mem[adr[10:2]] = dat_o;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  // passive monitor: logs beats, handshakes and per-cycle events
  int          cy = 0;
  always @(posedge clk) cy <= cy + 1;
  logic [31:0] ack_adr[$], ack_dat[$], rd_q[$];
  bit          ack_we[$];
  int          ack_cy[$], stb_cy[$], done_cy[$], acc_cy[$];
  int          wr_hs = 0, sel_bad = 0, hold_bad = 0;
  always @(negedge clk) begin
    if (cyc && stb && ack) begin
      ack_adr.push_back(adr);
      ack_dat.push_back(dat_o);
      ack_we.push_back(we);
      ack_cy.push_back(cy);
    end
    if (stb) stb_cy.push_back(cy);
    if (done) done_cy.push_back(cy);
    if (cmd_valid && cmd_ready) acc_cy.push_back(cy);
    if (wr_valid && wr_ready) wr_hs = wr_hs + 1;
    if (rd_valid && rd_ready) rd_q.push_back(rd_data);
    if (sel !== (stb ? 4'hF : 4'h0)) sel_bad = sel_bad + 1;
    if (rd_valid && cyc) hold_bad = hold_bad + 1;
  end

  // reference model: expected addresses by arithmetic, memory contents by byte address
  logic [31:0] ref_mem [bit [31:0]];
  logic [31:0] wq[$];
  int          vectors = 0, miscompares = 0;

  function automatic logic [31:0] exp_adr(input logic [31:0] base, input int i);
    return (base & 32'hFFFF_FFFC) + 32'(4 * i);
  endfunction

  task automatic model_write(input logic [31:0] base, input int len);
    for (int i = 0; i < len; i++) ref_mem[exp_adr(base, i)] = wq[i];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input bit we_i, input logic [31:0] base, input int len,
                         input bit gap, input int stall_word, input int budget);
    bit acc = 1'b0, fin = 1'b0, got = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = we_i;
    cmd_base  = base;
    cmd_len   = 10'(len);
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", 32'(acc), 32'd1);
    fork
      begin : src
        int i = 0;
        while (we_i && i < len && !fin) begin
          wr_valid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
          wr_data  = wq[i];
          @(negedge clk);
          if (wr_valid && wr_ready) i++;
          @(posedge clk);
          #1;
        end
        wr_valid = 1'b0;
      end
      begin : snk
        int k = 0, st = 0;
        while (!fin) begin
          rd_ready = !(k == stall_word && st < 5);
          @(negedge clk);
          if (rd_valid) begin
            if (rd_ready) k++;
            else st++;
          end
          @(posedge clk);
          #1;
        end
        rd_ready = 1'b0;
      end
      begin : wtch
        for (int c = 0; c < budget && !got; c++) begin
          @(negedge clk);
          got = done;
        end
        fin = 1'b1;
      end
    join
    chk("done_seen", 32'(got), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          n0, s0, d0, h0, r0, bad, k;
    bit          hit;
    logic [31:0] base, rb, a;
    logic [31:0] rv [3];
    rv = '{32'h11, 32'h22, 32'h33};

    // reset values
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // write 4 words, single-cycle ack latency
    wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    n0 = ack_adr.size(); d0 = done_cy.size(); h0 = wr_hs;
    run_cmd(1'b1, 32'h3000_0010, 4, 1'b0, -1, 200);
    model_write(32'h3000_0010, 4);
    chk("wr4_beats", 32'(ack_adr.size() - n0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("wr4_adr", ack_adr[n0 + i], exp_adr(32'h3000_0010, i));
      chk("wr4_dat", ack_dat[n0 + i], wq[i]);
      chk("wr4_we", 32'(ack_we[n0 + i]), 32'd1);
    end
    chk("wr4_done_count", 32'(done_cy.size() - d0), 32'd1);
    chk("wr4_done_latency", 32'(done_cy[$]), 32'(ack_cy[$] + 1));
    chk("wr4_stream", 32'(wr_hs - h0), 32'd4);
    chk("wr4_err", 32'(err), 32'd0);

    // read 3 preloaded words, consumer stalls 5 cycles on the second word
    base = 32'h3000_0103;
    for (int i = 0; i < 3; i++) begin
      a = exp_adr(base, i);
      mem[a[10:2]] = rv[i];
      ref_mem[a] = rv[i];
    end
    r0 = rd_q.size(); s0 = stb_cy.size(); n0 = ack_adr.size();
    run_cmd(1'b0, base, 3, 1'b0, 1, 300);
    chk("rd3_words", 32'(rd_q.size() - r0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("rd3_data", rd_q[r0 + i], ref_mem[exp_adr(base, i)]);
      chk("rd3_adr", ack_adr[n0 + i], exp_adr(base, i));
      chk("rd3_we", 32'(ack_we[n0 + i]), 32'd0);
    end
    chk("rd3_first_stb", 32'(stb_cy[s0]), 32'(acc_cy[$] + 1));
    chk("rd3_done_latency", 32'(done_cy[$]), 32'(rd_q.size() > 0 ? ack_cy[$] + 7 : -1) - 32'd5);

    // responder never acks: stb for exactly TIMEOUT cycles, then abort
    resp_en = 1'b0;
    wq = '{32'hB0, 32'hB1, 32'hB2};
    s0 = stb_cy.size(); d0 = done_cy.size(); h0 = wr_hs; n0 = ack_adr.size();
    run_cmd(1'b1, 32'h3000_0200, 3, 1'b0, -1, 100);
    resp_en = 1'b1;
    chk("to_stb_cycles", 32'(stb_cy.size() - s0), 32'd8);
    chk("to_stb_span", 32'(stb_cy[$] - stb_cy[s0]), 32'd7);
    chk("to_done_latency", 32'(done_cy[$]), 32'(stb_cy[$] + 1));
    chk("to_done_count", 32'(done_cy.size() - d0), 32'd1);
    chk("to_stream", 32'(wr_hs - h0), 32'd1);
    chk("to_beats", 32'(ack_adr.size() - n0), 32'd0);
    chk("to_err", 32'(err), 32'd1);

    // zero length: no bus activity, done one cycle after accept, err cleared
    s0 = stb_cy.size();
    run_cmd(1'b0, 32'h3000_0300, 0, 1'b0, -1, 20);
    chk("len0_err_cleared", 32'(err), 32'd0);
    chk("len0_no_cyc", 32'(stb_cy.size() - s0), 32'd0);
    chk("len0_done_latency", 32'(done_cy[$]), 32'(acc_cy[$] + 1));

    // address wrap at the top of the space
    wq = '{$urandom, $urandom};
    n0 = ack_adr.size();
    run_cmd(1'b1, 32'hFFFF_FFFC, 2, 1'b0, -1, 100);
    model_write(32'hFFFF_FFFC, 2);
    chk("wrap_beats", 32'(ack_adr.size() - n0), 32'd2);
    chk("wrap_adr0", ack_adr[n0], 32'hFFFF_FFFC);
    chk("wrap_adr1", ack_adr[n0 + 1], 32'h0000_0000);
    chk("wrap_dat1", ack_dat[n0 + 1], wq[1]);

    // reset during the bus phase of word 2 of 4
    lat = 5;
    n0 = ack_adr.size();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_base = 32'h3000_0400; cmd_len = 10'd4;
    @(negedge clk);
    chk("rst_cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 32'hC0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      hit = stb && !ack && (ack_adr.size() - n0 == 1);
    end
    chk("rst_reached_word2", 32'(hit), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_edge_stb", 32'(stb), 32'd1);
    @(negedge clk);
    chk("rst_mid_cyc", 32'(cyc), 32'd0);
    chk("rst_mid_stb", 32'(stb), 32'd0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; lat = 0;
    @(posedge clk);
    #1;
    stray = 1'b1;
    @(posedge clk);
    #1;
    stray = 1'b0;
    @(negedge clk);
    chk("stray_adr", adr, 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("stray_rd_data", rd_data, 32'd0);
    chk("stray_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;

    // maximum-length write with a randomly gapped source
    base = $urandom;
    wq.delete();
    for (int i = 0; i < 512; i++) wq.push_back($urandom);
    n0 = ack_adr.size(); h0 = wr_hs; d0 = done_cy.size();
    run_cmd(1'b1, base, 512, 1'b1, -1, 20000);
    model_write(base, 512);
    chk("wr512_beats", 32'(ack_adr.size() - n0), 32'd512);
    chk("wr512_stream", 32'(wr_hs - h0), 32'd512);
    chk("wr512_final_adr", ack_adr[$], (base & 32'hFFFF_FFFC) + 32'h7FC);
    bad = 0;
    for (int i = 0; i < 512 && n0 + i < ack_adr.size(); i++)
      if (ack_adr[n0 + i] !== exp_adr(base, i) || ack_dat[n0 + i] !== wq[i]) bad++;
    chk("wr512_beat_errors", 32'(bad), 32'd0);
    chk("wr512_done_count", 32'(done_cy.size() - d0), 32'd1);
    chk("wr512_err", 32'(err), 32'd0);

    // read back a random 16-word window of that block
    k = $urandom_range(0, 496);
    rb = exp_adr(base, k);
    r0 = rd_q.size();
    run_cmd(1'b0, rb, 16, 1'b0, $urandom_range(0, 15), 600);
    chk("rb_words", 32'(rd_q.size() - r0), 32'd16);
    bad = 0;
    for (int j = 0; j < 16 && r0 + j < rd_q.size(); j++)
      if (rd_q[r0 + j] !== ref_mem[exp_adr(rb, j)]) bad++;
    chk("rb_data_errors", 32'(bad), 32'd0);

    chk("sel_every_beat", 32'(sel_bad), 32'd0);
    chk("no_cyc_in_hold", 32'(hold_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
